tmds_pll_mode_ctrl: RTL

//  Runtime video-mode controller for the TMDS PLL. Runs on the free-running 50 MHz board clock.

---
 rtl/tmds_pll_mode_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/tmds_pll_mode_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tmds_pll_mode_ctrl
// Brief    : TMDS PLL video-mode controller. Drives the PLL dividers from a mode
//            table, sequences PLL reset and lock qualification, and produces a
//            clean pixel-domain reset. Define TMDS_PLL_LOSS_CNT_EN to add the
//            lock_loss_cnt output.
// Revision : 1.0  initial release
// =============================================================================
module tmds_pll_mode_ctrl #(
    parameter int NUM_MODES        = 4,
    parameter int MODE_W           = 2,
    parameter int DEFAULT_MODE     = 0,
    parameter int RESET_HOLD_CYC   = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 500000,
    parameter int MAX_RETRIES      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_req_valid,
    input  logic [MODE_W-1:0] mode_req,
    output logic              mode_req_ready,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic [6:0]        mdiv_sel,
    output logic [6:0]        odiv0_sel,
    output logic [6:0]        odiv1_sel,
    output logic [MODE_W-1:0] cur_mode,
    output logic              locked,
    output logic              video_rst_n,
    output logic              fail
`ifdef TMDS_PLL_LOSS_CNT_EN
    ,
    output logic [7:0]        lock_loss_cnt
`endif
);

    localparam int c_HOLD_W = (RESET_HOLD_CYC > 1) ? $clog2(RESET_HOLD_CYC) : 1;
    localparam int c_STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
    localparam int c_TMO_W  = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;
    localparam int c_RTY_W  = $clog2(MAX_RETRIES + 1);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_HOLD_CYC - 1);
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [c_RTY_W-1:0]  c_RTY_LAST  = c_RTY_W'(MAX_RETRIES - 1);
    localparam logic [MODE_W-1:0]   c_DEF_MODE  = MODE_W'(DEFAULT_MODE);

    typedef enum logic [2:0] {
        ST_APPLY     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_lock_meta;
    logic                r_lock_s;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_STAB_W-1:0] r_stab_cnt;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic [c_RTY_W-1:0]  r_retry;

    logic                w_accept;
    logic                w_tmo_done;
    logic [MODE_W-1:0]   w_req_mode;

    // {MDIV, ODIV0, ODIV1}
    function automatic logic [20:0] f_divs(input logic [MODE_W-1:0] idx);
        logic [31:0] v;
        v = 32'(idx);
        case (v)
            32'd1:   f_divs = {7'd15, 7'd6, 7'd30};
            32'd2:   f_divs = {7'd15, 7'd2, 7'd10};
            32'd3:   f_divs = {7'd13, 7'd2, 7'd10};
            default: f_divs = {7'd16, 7'd4, 7'd20};
        endcase
    endfunction

    assign mode_req_ready = (r_state == ST_RUN) || (r_state == ST_FAIL);
    assign w_accept       = mode_req_valid && mode_req_ready;
    assign w_req_mode     = (32'(mode_req) >= 32'(NUM_MODES)) ? c_DEF_MODE : mode_req;
    assign w_tmo_done     = (r_tmo_cnt >= c_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state                           <= ST_APPLY;
            r_hold_cnt                        <= '0;
            r_stab_cnt                        <= '0;
            r_tmo_cnt                         <= '0;
            r_retry                           <= '0;
            pll_reset                         <= 1'b1;
            {mdiv_sel, odiv0_sel, odiv1_sel}  <= f_divs(c_DEF_MODE);
            cur_mode                          <= c_DEF_MODE;
            locked                            <= 1'b0;
            video_rst_n                       <= 1'b0;
            fail                              <= 1'b0;
        end else if (w_accept) begin
            // An accepted request wins over a simultaneous lock loss in RUN.
            r_state                           <= ST_APPLY;
            r_hold_cnt                        <= '0;
            r_retry                           <= '0;
            pll_reset                         <= 1'b1;
            {mdiv_sel, odiv0_sel, odiv1_sel}  <= f_divs(w_req_mode);
            cur_mode                          <= w_req_mode;
            locked                            <= 1'b0;
            video_rst_n                       <= 1'b0;
            fail                              <= 1'b0;
        end else begin
            case (r_state)
                ST_APPLY: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state   <= ST_WAIT_LOCK;
                        r_tmo_cnt <= '0;
                        pll_reset <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        // The cycle that qualified the lock is the first stable one.
                        r_state    <= ST_STABLE;
                        r_stab_cnt <= c_STAB_W'(1);
                        if (!w_tmo_done) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end else if (w_tmo_done) begin
                        r_retry    <= r_retry + 1'b1;
                        r_hold_cnt <= '0;
                        pll_reset  <= 1'b1;
                        if (r_retry == c_RTY_LAST) begin
                            r_state <= ST_FAIL;
                            fail    <= 1'b1;
                        end else begin
                            r_state <= ST_APPLY;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!w_tmo_done) r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    if (!r_lock_s) begin
                        r_state <= ST_WAIT_LOCK;
                    end else if (r_stab_cnt >= c_STAB_LAST) begin
                        r_state     <= ST_RUN;
                        r_retry     <= '0;
                        locked      <= 1'b1;
                        video_rst_n <= 1'b1;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!r_lock_s) begin
                        r_state     <= ST_APPLY;
                        r_hold_cnt  <= '0;
                        pll_reset   <= 1'b1;
                        locked      <= 1'b0;
                        video_rst_n <= 1'b0;
                    end
                end
                ST_FAIL: begin
                    pll_reset   <= 1'b1;
                    video_rst_n <= 1'b0;
                    fail        <= 1'b1;
                end
                default: begin
                    r_state    <= ST_APPLY;
                    r_hold_cnt <= '0;
                    pll_reset  <= 1'b1;
                end
            endcase
        end
    end

`ifdef TMDS_PLL_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    // Counts every lock loss seen in RUN, including one coinciding with a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss_cnt <= 8'd0;
        end else if ((r_state == ST_RUN) && !r_lock_s && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule
`default_nettype wire
